change_return_dispenser: RTL
============================

// Module: change_return_dispenser
// PURPOSE
//  Consumer end of the change-return trigger counter. Watches the hold-count of the return
//  button; when the count reaches WAIT_CYCLES, it latches the machine balance. It then pays
//  the balance out greedily, one coin per clock, largest denomination first. It reports
//  completion and any residual value that no coin can represent.
// PARAMETERS
//  TOTAL_BITS   31    width of balance, trigger point and totals
//  WAIT_CYCLES  3     trigger-point value that starts a return (must be >= 1)
//  COIN0_VAL    100   smallest coin value
//  COIN1_VAL    500   middle coin value
//  COIN2_VAL    1000  largest coin value (COIN0_VAL < COIN1_VAL < COIN2_VAL, all > 0)
// PORTS
//  clk                 in   1           clock, all logic on posedge
//  reset_n             in   1           synchronous reset, active-low
//  i_trigger_point     in   TOTAL_BITS  consecutive-cycle hold count of return button (0 when released)
//  i_current_total     in   TOTAL_BITS  machine balance available for return
//  o_return_coin       out  3           one-hot coin released this cycle: [2]=COIN2 [1]=COIN1 [0]=COIN0
//  o_busy              out  1           1 while a return is in progress (DISPENSE or DONE)
//  o_return_done       out  1           single-cycle pulse at end of a return
//  o_returned_total    out  TOTAL_BITS  sum of coin values released in current/last return
//  o_residual          out  TOTAL_BITS  unreturnable remainder of current/last return
// BEHAVIOUR
//  - All outputs registered. Reset (reset_n==0 at a posedge) takes priority over everything:
//    state=IDLE, o_return_coin=0, o_busy=0, o_return_done=0, o_returned_total=0, o_residual=0,
//    internal remaining=0. Reset mid-return aborts it immediately, with no done pulse.
//  - States: IDLE, DISPENSE, DONE.
//  - IDLE: at the edge where i_trigger_point == WAIT_CYCLES (exact equality, so one start per
//    button hold): remaining <= i_current_total, o_returned_total <= 0, o_residual <= 0,
//    o_busy <= 1, state <= DISPENSE.
//    Otherwise stay in IDLE with outputs held; o_returned_total and o_residual keep their last values.
//  - DISPENSE, at each edge:
//    - Select the largest COINk_VAL <= remaining.
//    - If one exists: set the one-hot bit of o_return_coin, remaining -= COINk_VAL,
//      o_returned_total += COINk_VAL, and stay in DISPENSE.
//    - If none exists (including remaining==0): o_return_coin <= 0, o_residual <= remaining,
//      o_return_done <= 1, state <= DONE.
//  - DONE (lasts exactly one cycle): at the next edge, o_return_done <= 0, o_busy <= 0,
//    state <= IDLE.
//  - Zero balance at trigger still passes through DISPENSE and DONE: no coins, done pulse,
//    residual 0.
//  - Latency: trigger match at edge E0 -> first coin visible after E1 -> N coins occupy
//    E1..EN -> done pulse visible after E(N+1). Total busy = N+2 cycles.
//  - i_trigger_point and i_current_total are ignored while busy. A trigger held across the end
//    of a return does not restart it unless the count passes WAIT_CYCLES again after a release.
//  - o_return_coin has at most one bit set, and is nonzero only in cycles where the state is DISPENSE.
//  - Arithmetic: unsigned TOTAL_BITS. Subtraction is never negative by construction. Invariant at
//    done: o_returned_total + o_residual == latched balance.
// TESTING
//  1. balance 1700, trigger_point ramps 0,1,2,3 -> coins 1000,500,100,100 on 4 consecutive
//     cycles, done pulse next cycle, returned_total=1700, residual=0, busy high 6 cycles.
//  2. balance 150, trigger reaches 3 -> one 100 coin, done, returned_total=100, residual=50.
//  3. trigger_point goes 1,2,0 (release before WAIT_CYCLES) with balance 500 -> no coins,
//     busy stays 0, no done pulse.
//  4. balance 0, trigger reaches 3 -> no coins, done pulse 2 cycles after match, residual=0.
//  5. balance 3000, assert reset_n=0 after the 2nd coin -> next cycle all outputs 0, state IDLE,
//     no done pulse. A later trigger restarts cleanly.
//  6. trigger held to 10 during a 1000-coin return, i_current_total changed mid-return ->
//     latched value used, single return only.

Source files
------------

// File: rtl/change_return_dispenser.sv
// Change-return dispenser: latches the balance when the return button has been held for
// WAIT_CYCLES clocks, then pays it out one coin per clock, largest denomination first.
module change_return_dispenser #(
   parameter int TOTAL_BITS  = 31,
   parameter int WAIT_CYCLES = 3,
   parameter int COIN0_VAL   = 100,
   parameter int COIN1_VAL   = 500,
   parameter int COIN2_VAL   = 1000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [TOTAL_BITS-1:0] i_trigger_point,
   input  logic [TOTAL_BITS-1:0] i_current_total,
   output logic [2:0]            o_return_coin,
   output logic                  o_busy,
   output logic                  o_return_done,
   output logic [TOTAL_BITS-1:0] o_returned_total,
   output logic [TOTAL_BITS-1:0] o_residual
);

   localparam logic [TOTAL_BITS-1:0] WAIT_V = TOTAL_BITS'(WAIT_CYCLES);
   localparam logic [TOTAL_BITS-1:0] C0     = TOTAL_BITS'(COIN0_VAL);
   localparam logic [TOTAL_BITS-1:0] C1     = TOTAL_BITS'(COIN1_VAL);
   localparam logic [TOTAL_BITS-1:0] C2     = TOTAL_BITS'(COIN2_VAL);

   typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

   state_t                state;
   logic [TOTAL_BITS-1:0] remaining;
   logic [2:0]            coin_sel;
   logic [TOTAL_BITS-1:0] coin_amt;

   // Greedy pick: largest coin that still fits; none selected means the return is finished.
   always_comb begin
      coin_sel = 3'b000;
      coin_amt = '0;
      if (remaining >= C2) begin
         coin_sel = 3'b100;
         coin_amt = C2;
      end else if (remaining >= C1) begin
         coin_sel = 3'b010;
         coin_amt = C1;
      end else if (remaining >= C0) begin
         coin_sel = 3'b001;
         coin_amt = C0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state            <= IDLE;
         remaining        <= '0;
         o_return_coin    <= 3'b000;
         o_busy           <= 1'b0;
         o_return_done    <= 1'b0;
         o_returned_total <= '0;
         o_residual       <= '0;
      end else begin
         case (state)
            IDLE: begin
               o_return_coin <= 3'b000;
               o_return_done <= 1'b0;
               // Exact match fires once per hold since the count keeps climbing.
               if (i_trigger_point == WAIT_V) begin
                  remaining        <= i_current_total;
                  o_returned_total <= '0;
                  o_residual       <= '0;
                  o_busy           <= 1'b1;
                  state            <= DISPENSE;
               end
            end
            DISPENSE: begin
               if (coin_sel != 3'b000) begin
                  o_return_coin    <= coin_sel;
                  remaining        <= remaining - coin_amt;
                  o_returned_total <= o_returned_total + coin_amt;
               end else begin
                  o_return_coin <= 3'b000;
                  o_residual    <= remaining;
                  o_return_done <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               o_return_coin <= 3'b000;
               o_return_done <= 1'b0;
               o_busy        <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               o_return_coin <= 3'b000;
               o_return_done <= 1'b0;
               o_busy        <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule
